// File: rtl/rst_sequencer.sv
// Reset sequencer for the MMCM clock domain: synchronizes lock, qualifies it
// for a stable window, holds reset a few more cycles, then releases o_rst.
module rst_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_locked,
  output logic       o_rst,
  output logic       o_ready,
  output logic [1:0] o_state,
  output logic [7:0] o_lock_lost_cnt
);

  localparam int MAXC = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES
                                                               : RST_HOLD_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   locked_s;
  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [7:0]             lost_nxt;

  // i_locked is asynchronous to i_clk; only the last stage feeds the FSM
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) sync <= '0;
    else         sync <= {sync[SYNC_STAGES-2:0], i_locked};
  end

  assign locked_s = sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state           <= WAIT_LOCK;
      cnt             <= '0;
      o_lock_lost_cnt <= '0;
      o_rst           <= 1'b1;
      o_ready         <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      o_lock_lost_cnt <= lost_nxt;
      o_rst           <= (state_nxt != RUN);
      o_ready         <= (state_nxt == RUN);
    end
  end

  // Loss of lock always wins over a counter reaching its terminal value
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lost_nxt  = o_lock_lost_cnt;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (locked_s) state_nxt = STABLE;
      end
      STABLE: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
          if (o_lock_lost_cnt != 8'hFF) lost_nxt = o_lock_lost_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign o_state = state;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with SYNC_STAGES=2, LOCK_STABLE_CYCLES=8,
// RST_HOLD_CYCLES=4, giving a 15-edge qualification and 3-edge loss latency.
module tb_rst_sequencer;

  logic       clk;
  logic       reset;
  logic       locked;
  logic       rst;
  logic       ready;
  logic [1:0] state;
  logic [7:0] lost;

  int n_cmp = 0;
  int n_err = 0;

  rst_sequencer #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(8),
    .RST_HOLD_CYCLES   (4)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_locked       (locked),
    .o_rst          (rst),
    .o_ready        (ready),
    .o_state        (state),
    .o_lock_lost_cnt(lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects i_locked already high; edge 1 is the next rising edge.
  // Hand-derived: WAIT through edge 2, STABLE edges 3-10, HOLD 11-14, RUN at 15.
  task automatic qualify(input string tag);
    logic [1:0] es;
    for (int e = 1; e <= 15; e++) begin
      tick();
      es = (e <= 2) ? 2'd0 : (e <= 10) ? 2'd1 : (e <= 14) ? 2'd2 : 2'd3;
      chk($sformatf("%s_e%0d_state", tag, e), 32'(state), 32'(es));
      chk($sformatf("%s_e%0d_rst", tag, e), 32'(rst), (e < 15) ? 32'd1 : 32'd0);
      chk($sformatf("%s_e%0d_ready", tag, e), 32'(ready), (e < 15) ? 32'd0 : 32'd1);
    end
  endtask

  // From RUN: drop lock, expect WAIT_LOCK with reset asserted three edges later
  task automatic lose_lock(input string tag);
    locked = 1'b0;
    tick();
    tick();
    chk({tag, "_e2_rst"}, 32'(rst), 32'd0);
    tick();
    chk({tag, "_e3_rst"}, 32'(rst), 32'd1);
    chk({tag, "_e3_ready"}, 32'(ready), 32'd0);
    chk({tag, "_e3_state"}, 32'(state), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    locked = 1'b0;
    #1;
    chk("rst_async_rst", 32'(rst), 32'd1);
    chk("rst_async_ready", 32'(ready), 32'd0);
    chk("rst_async_state", 32'(state), 32'd0);
    chk("rst_async_lost", 32'(lost), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_rst", 32'(rst), 32'd1);

    // clean qualification
    locked = 1'b1;
    qualify("q1");
    chk("q1_lost", 32'(lost), 32'd0);

    // lock loss in RUN
    lose_lock("loss1");
    chk("loss1_lost", 32'(lost), 32'd1);

    // glitch in STABLE at cnt=5: STABLE entered edge 3, cnt=5 after edge 8
    locked = 1'b1;
    for (int e = 1; e <= 8; e++) tick();
    chk("gl_e8_state", 32'(state), 32'd1);
    locked = 1'b0;
    tick();
    tick();
    chk("gl_e10_state", 32'(state), 32'd1);
    chk("gl_e10_rst", 32'(rst), 32'd1);
    // cnt reaches 7 at edge 10, but the captured low must win at edge 11
    locked = 1'b1;
    qualify("q2");

    // saturation: 299 more losses make 300 total
    for (int k = 2; k <= 300; k++) begin
      locked = 1'b0;
      for (int j = 0; j < 3; j++) tick();
      chk($sformatf("sat_k%0d", k), 32'(lost), (k < 255) ? 32'(k) : 32'd255);
      locked = 1'b1;
      for (int j = 0; j < 15; j++) tick();
    end
    chk("sat_final_lost", 32'(lost), 32'd255);
    chk("sat_final_state", 32'(state), 32'd3);

    // reset mid-HOLD, between edges
    locked = 1'b0;
    for (int j = 0; j < 3; j++) tick();
    locked = 1'b1;
    for (int e = 1; e <= 12; e++) tick();
    chk("midhold_state", 32'(state), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("midhold_rst", 32'(rst), 32'd1);
    chk("midhold_ready", 32'(ready), 32'd0);
    chk("midhold_state0", 32'(state), 32'd0);
    chk("midhold_lost", 32'(lost), 32'd0);
    #1;
    reset = 1'b0;
    qualify("q3");
    chk("q3_lost", 32'(lost), 32'd0);

    // reset mid-RUN, between edges
    tick();
    chk("run_ready", 32'(ready), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("midrun_rst", 32'(rst), 32'd1);
    chk("midrun_ready", 32'(ready), 32'd0);
    chk("midrun_state", 32'(state), 32'd0);
    #1;
    reset = 1'b0;
    qualify("q4");
    chk("q4_lost", 32'(lost), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
